// File: rtl/hzd_ctrl_sb.sv
// Pipeline hazard controller: operand forwarding selects, stall/flush generation,
// and a scoreboard tracking outstanding long-latency (mul/div) writebacks.
module hzd_ctrl_sb #(
  parameter int unsigned RIDX_W   = 5,
  parameter int unsigned LU_DEPTH = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RIDX_W-1:0] i_rs1idx_d,
  input  logic [RIDX_W-1:0] i_rs2idx_d,
  input  logic [RIDX_W-1:0] i_rdidx_d,
  input  logic              i_rdwen_d,
  input  logic              i_brh_d,
  input  logic              i_lu_d,
  input  logic [RIDX_W-1:0] i_fwd_rs1idx,
  input  logic [RIDX_W-1:0] i_fwd_rs2idx,
  input  logic [RIDX_W-1:0] i_rdidx_e,
  input  logic              i_rdwen_e,
  input  logic              i_memrd_e,
  input  logic [RIDX_W-1:0] i_rdidx_mem,
  input  logic              i_rdwen_mem,
  input  logic              i_memrd_mem,
  input  logic [RIDX_W-1:0] i_rdidx_wb,
  input  logic              i_rdwen_wb,
  input  logic              i_lu_issue,
  input  logic              i_lu_done,
  input  logic [RIDX_W-1:0] i_lu_rdidx,
  input  logic [RIDX_W-1:0] i_lu_done_rdidx,
  input  logic              i_exu_jump,
  output logic [1:0]        o_fwd_rs1_d,
  output logic [1:0]        o_fwd_rs2_d,
  output logic [1:0]        o_fwd_rs1_e,
  output logic [1:0]        o_fwd_rs2_e,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_flush_f,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_sb_busy,
  output logic              o_sb_err,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int unsigned NREG = 1 << RIDX_W;
  localparam int unsigned CW   = $clog2(LU_DEPTH + 1);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use, brh_hzd, sb_hzd, struct_hzd, stall;
  logic issue_ok, done_ok;

  // Nonzero source index matching an enabled destination
  function automatic logic hit(input logic [RIDX_W-1:0] src,
                               input logic [RIDX_W-1:0] rd,
                               input logic              en);
    return en && (src != '0) && (src == rd);
  endfunction

  // MEM wins over WB; a MEM-stage load has no data yet so it cannot forward
  function automatic logic [1:0] fwd_sel(input logic [RIDX_W-1:0] src,
                                         input logic [RIDX_W-1:0] rd_mem,
                                         input logic              fwd_mem,
                                         input logic [RIDX_W-1:0] rd_wb,
                                         input logic              wen_wb);
    if (hit(src, rd_mem, fwd_mem)) return 2'b10;
    if (hit(src, rd_wb, wen_wb))   return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    o_fwd_rs1_e = fwd_sel(i_fwd_rs1idx, i_rdidx_mem, i_rdwen_mem && !i_memrd_mem,
                          i_rdidx_wb, i_rdwen_wb);
    o_fwd_rs2_e = fwd_sel(i_fwd_rs2idx, i_rdidx_mem, i_rdwen_mem && !i_memrd_mem,
                          i_rdidx_wb, i_rdwen_wb);
    o_fwd_rs1_d = fwd_sel(i_rs1idx_d, i_rdidx_mem, i_rdwen_mem && !i_memrd_mem,
                          i_rdidx_wb, i_rdwen_wb);
    o_fwd_rs2_d = fwd_sel(i_rs2idx_d, i_rdidx_mem, i_rdwen_mem && !i_memrd_mem,
                          i_rdidx_wb, i_rdwen_wb);
  end

  always_comb begin
    load_use = i_memrd_e && i_rdwen_e &&
               (hit(i_rs1idx_d, i_rdidx_e, 1'b1) || hit(i_rs2idx_d, i_rdidx_e, 1'b1));
    brh_hzd  = i_brh_d &&
               (hit(i_rs1idx_d, i_rdidx_e, i_rdwen_e) ||
                hit(i_rs2idx_d, i_rdidx_e, i_rdwen_e) ||
                hit(i_rs1idx_d, i_rdidx_mem, i_rdwen_mem && i_memrd_mem) ||
                hit(i_rs2idx_d, i_rdidx_mem, i_rdwen_mem && i_memrd_mem));
    // Same-cycle issue counts as pending so D cannot slip past it
    sb_hzd   = pending_q[i_rs1idx_d] || pending_q[i_rs2idx_d] ||
               (i_rdwen_d && pending_q[i_rdidx_d]) ||
               hit(i_rs1idx_d, i_lu_rdidx, i_lu_issue) ||
               hit(i_rs2idx_d, i_lu_rdidx, i_lu_issue) ||
               (i_rdwen_d && hit(i_rdidx_d, i_lu_rdidx, i_lu_issue));
    struct_hzd = i_lu_d && (count_q == CW'(LU_DEPTH));
    stall      = load_use || brh_hzd || sb_hzd || struct_hzd;

    o_flush_f = i_exu_jump;
    o_flush_d = i_exu_jump;
    o_stall_f = stall && !i_exu_jump;
    o_stall_d = stall && !i_exu_jump;
    o_flush_e = stall && !i_exu_jump;
  end

  // Scoreboard update; a done to the register being re-issued lets the issue win
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    done_ok  = i_lu_done && (count_q != '0) &&
               (pending_q[i_lu_done_rdidx] || (i_lu_done_rdidx == '0));
    issue_ok = i_lu_issue && (count_q < CW'(LU_DEPTH)) &&
               (!pending_q[i_lu_rdidx] || (done_ok && (i_lu_done_rdidx == i_lu_rdidx)));

    if ((i_lu_issue && !issue_ok) || (i_lu_done && !done_ok)) err_d = 1'b1;
    if (done_ok)  pending_d[i_lu_done_rdidx] = 1'b0;
    if (issue_ok) pending_d[i_lu_rdidx]      = 1'b1;
    pending_d[0] = 1'b0;

    if (issue_ok && !done_ok)      count_d = count_q + CW'(1);
    else if (!issue_ok && done_ok) count_d = count_q - CW'(1);

    if (o_stall_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_sb_busy   = (count_q != '0);
  assign o_sb_err    = err_q;
  assign o_stall_cnt = cnt_q;

endmodule
